// File: rtl/dispensador_billetes_if.sv
// Signal bundle between the transaction controller / bill feeder and dispensador_billetes.
// The slave modport is the sequencer's view; master is the controller/mechanism side.
interface dispensador_billetes_if #(
  parameter int unsigned INV_W = 8
);
  logic             ENTREGAR_DINERO;
  logic [31:0]      MONTO;
  logic             CARGA_STB;
  logic [1:0]       CARGA_DENOM;
  logic [INV_W-1:0] CARGA_CANT;
  logic             BILLETE_ACK;
  logic             BILLETE_REQ;
  logic [1:0]       BILLETE_DENOM;
  logic             OCUPADO;
  logic             ENTREGA_COMPLETA;
  logic             MONTO_INVALIDO;
  logic             FALLA_MECANISMO;

  modport slave (
    input  ENTREGAR_DINERO, MONTO, CARGA_STB, CARGA_DENOM, CARGA_CANT, BILLETE_ACK,
    output BILLETE_REQ, BILLETE_DENOM, OCUPADO, ENTREGA_COMPLETA, MONTO_INVALIDO, FALLA_MECANISMO
  );

  modport master (
    output ENTREGAR_DINERO, MONTO, CARGA_STB, CARGA_DENOM, CARGA_CANT, BILLETE_ACK,
    input  BILLETE_REQ, BILLETE_DENOM, OCUPADO, ENTREGA_COMPLETA, MONTO_INVALIDO, FALLA_MECANISMO
  );
endinterface

// File: rtl/dispensador_billetes.sv
// Greedy cash-dispenser sequencer: splits MONTO into bills against a per-denomination
// inventory and feeds them one by one over REQ/ACK. Macro DISPENSADOR_TIMEOUT_EN adds an ACK timeout.
module dispensador_billetes #(
  parameter int unsigned DEN0           = 20000,
  parameter int unsigned DEN1           = 10000,
  parameter int unsigned DEN2           = 5000,
  parameter int unsigned DEN3           = 1000,
  parameter int unsigned INV_W          = 8,
  parameter int unsigned TIMEOUT_CICLOS = 255
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dispensador_billetes_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC     = 3'd1,
    SOLICITA = 3'd2,
    PAUSA    = 3'd3,
    FIN      = 3'd4,
    RECHAZO  = 3'd5
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [31:0]      rem_q, rem_d;
  logic [1:0]       idx_q, idx_d;
  logic [INV_W-1:0] n_q   [4];
  logic [INV_W-1:0] n_d   [4];
  logic [INV_W-1:0] inv_q [4];
  logic [INV_W-1:0] inv_d [4];
  logic             req_q, req_d;
  logic [1:0]       denom_q, denom_d;
  logic             ocupado_q, ocupado_d;
  logic             completa_q, completa_d;
  logic             invalido_q, invalido_d;
  logic             todos_cero;

`ifdef DISPENSADOR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CICLOS + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             falla_q, falla_d;
`endif

  function automatic logic [31:0] den_valor(input logic [1:0] idx);
    case (idx)
      2'd0:    den_valor = 32'(DEN0);
      2'd1:    den_valor = 32'(DEN1);
      2'd2:    den_valor = 32'(DEN2);
      default: den_valor = 32'(DEN3);
    endcase
  endfunction

  function automatic logic [INV_W-1:0] suma_sat(input logic [INV_W-1:0] a, input logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[INV_W]) suma_sat = {INV_W{1'b1}};
    else          suma_sat = s[INV_W-1:0];
  endfunction

  assign todos_cero = (n_q[0] == {INV_W{1'b0}}) && (n_q[1] == {INV_W{1'b0}}) &&
                      (n_q[2] == {INV_W{1'b0}}) && (n_q[3] == {INV_W{1'b0}});

  // Next-state, working registers, inventory and registered-output values.
  always_comb begin
    estado_d = estado_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    for (int k = 0; k < 4; k++) begin
      n_d[k]   = n_q[k];
      inv_d[k] = inv_q[k];
    end
`ifdef DISPENSADOR_TIMEOUT_EN
    cnt_d   = {CNT_W{1'b0}};
    falla_d = 1'b0;
`endif

    case (estado_q)
      IDLE: begin
        if (bus.ENTREGAR_DINERO) begin
          rem_d = bus.MONTO;
          idx_d = 2'd0;
          for (int k = 0; k < 4; k++) n_d[k] = {INV_W{1'b0}};
          if (bus.MONTO == 32'd0) estado_d = RECHAZO;
          else                    estado_d = CALC;
        end else if (bus.CARGA_STB) begin
          inv_d[bus.CARGA_DENOM] = suma_sat(inv_q[bus.CARGA_DENOM], bus.CARGA_CANT);
        end else begin
          estado_d = IDLE;
        end
      end
      CALC: begin
        // Compare before subtracting so rem never underflows.
        if ((rem_q >= den_valor(idx_q)) && (n_q[idx_q] < inv_q[idx_q])) begin
          rem_d      = rem_q - den_valor(idx_q);
          n_d[idx_q] = n_q[idx_q] + INV_W'(1);
        end else if (idx_q == 2'd3) begin
          idx_d = 2'd0;
          if (rem_q == 32'd0) estado_d = SOLICITA;
          else                estado_d = RECHAZO;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      SOLICITA: begin
        if (todos_cero) begin
          estado_d = FIN;
        end else if (n_q[idx_q] == {INV_W{1'b0}}) begin
          idx_d = idx_q + 2'd1;
        end else if (req_q && bus.BILLETE_ACK) begin
          n_d[idx_q]   = n_q[idx_q] - INV_W'(1);
          inv_d[idx_q] = inv_q[idx_q] - INV_W'(1);
          estado_d     = PAUSA;
        end else begin
`ifdef DISPENSADOR_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1)) begin
            estado_d = IDLE;
            falla_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          estado_d = SOLICITA;
`endif
        end
      end
      // Going straight to FIN after the last bill makes the completion pulse follow the last ACK by one cycle.
      PAUSA: begin
        if (todos_cero) estado_d = FIN;
        else            estado_d = SOLICITA;
      end
      FIN:     estado_d = IDLE;
      RECHAZO: estado_d = IDLE;
      default: estado_d = IDLE;
    endcase

    req_d      = (estado_d == SOLICITA) && (n_d[idx_d] != {INV_W{1'b0}});
    if (req_d) denom_d = idx_d;
    else       denom_d = 2'd0;
    ocupado_d  = (estado_d != IDLE);
    completa_d = (estado_d == FIN);
    invalido_d = (estado_d == RECHAZO);
  end

  // State, working registers, inventory and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      estado_q   <= IDLE;
      rem_q      <= 32'd0;
      idx_q      <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        n_q[k]   <= {INV_W{1'b0}};
        inv_q[k] <= {INV_W{1'b0}};
      end
      req_q      <= 1'b0;
      denom_q    <= 2'd0;
      ocupado_q  <= 1'b0;
      completa_q <= 1'b0;
      invalido_q <= 1'b0;
`ifdef DISPENSADOR_TIMEOUT_EN
      cnt_q      <= {CNT_W{1'b0}};
      falla_q    <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      for (int k = 0; k < 4; k++) begin
        n_q[k]   <= n_d[k];
        inv_q[k] <= inv_d[k];
      end
      req_q      <= req_d;
      denom_q    <= denom_d;
      ocupado_q  <= ocupado_d;
      completa_q <= completa_d;
      invalido_q <= invalido_d;
`ifdef DISPENSADOR_TIMEOUT_EN
      cnt_q      <= cnt_d;
      falla_q    <= falla_d;
`endif
    end
  end

  assign bus.BILLETE_REQ      = req_q;
  assign bus.BILLETE_DENOM    = denom_q;
  assign bus.OCUPADO          = ocupado_q;
  assign bus.ENTREGA_COMPLETA = completa_q;
  assign bus.MONTO_INVALIDO   = invalido_q;
`ifdef DISPENSADOR_TIMEOUT_EN
  assign bus.FALLA_MECANISMO  = falla_q;
`else
  assign bus.FALLA_MECANISMO  = 1'b0;
`endif

endmodule

// File: tb/tb_dispensador_billetes.sv
// Directed bench for dispensador_billetes: greedy split, inventory effects, rejection,
// ACK stall, asynchronous reset and (with DISPENSADOR_TIMEOUT_EN) the ACK timeout.
module tb_dispensador_billetes;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dispensador_billetes_if #(.INV_W(8)) bus ();

  dispensador_billetes #(
    .DEN0(20000), .DEN1(10000), .DEN2(5000), .DEN3(1000),
    .INV_W(8), .TIMEOUT_CICLOS(20)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic verificar(input string nombre, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nombre, obs, esp);
    end
  endtask

  task automatic reinicio();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  task automatic cargar(input logic [1:0] den, input logic [7:0] cant);
    @(posedge clk); #1;
    bus.CARGA_STB   = 1'b1;
    bus.CARGA_DENOM = den;
    bus.CARGA_CANT  = cant;
    @(posedge clk); #1;
    bus.CARGA_STB   = 1'b0;
  endtask

  task automatic pedir(input logic [31:0] monto);
    @(posedge clk); #1;
    bus.ENTREGAR_DINERO = 1'b1;
    bus.MONTO           = monto;
    @(posedge clk); #1;
    bus.ENTREGAR_DINERO = 1'b0;
  endtask

  // e0..e3: expected bill counts per denomination (0 in all = expect rejection).
  task automatic entregar(input string tag, input logic [31:0] monto,
                          input int e0, input int e1, input int e2, input int e3,
                          input int lat, input int hold);
    int cnt [4];
    int nb, t, k, acc, reqs;
    cnt = '{e0, e1, e2, e3};
    nb  = e0 + e1 + e2 + e3;
    pedir(monto);
    verificar({tag, " ocupado"}, 32'(bus.OCUPADO), 32'd1);
    if (nb == 0) begin
      t = 0; reqs = 0;
      while (!bus.MONTO_INVALIDO && t < 400) begin
        if (bus.BILLETE_REQ) reqs++;
        @(posedge clk); #1; t++;
      end
      verificar({tag, " invalido"}, 32'(bus.MONTO_INVALIDO), 32'd1);
      verificar({tag, " sin req"}, 32'(reqs), 32'd0);
      @(posedge clk); #1;
      verificar({tag, " invalido pulso"}, 32'(bus.MONTO_INVALIDO), 32'd0);
      verificar({tag, " ocupado fin"}, 32'(bus.OCUPADO), 32'd0);
    end else begin
      for (int b = 0; b < nb; b++) begin
        k = 0; acc = cnt[0];
        while (b >= acc && k < 3) begin k++; acc += cnt[k]; end
        t = 0;
        while (!bus.BILLETE_REQ && t < 400) begin @(posedge clk); #1; t++; end
        if (b == 0 && lat >= 0) verificar({tag, " latencia"}, 32'(t), 32'(lat));
        verificar({tag, " req"}, 32'(bus.BILLETE_REQ), 32'd1);
        verificar({tag, " denom"}, 32'(bus.BILLETE_DENOM), 32'(k));
        if (b == 0 && hold > 0) begin
          bus.ENTREGAR_DINERO = 1'b1;
          bus.MONTO           = 32'd2000;
          bus.CARGA_STB       = 1'b1;
          bus.CARGA_DENOM     = 2'd3;
          bus.CARGA_CANT      = 8'd5;
          for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            verificar({tag, " req espera"}, 32'(bus.BILLETE_REQ), 32'd1);
            verificar({tag, " denom espera"}, 32'(bus.BILLETE_DENOM), 32'(k));
          end
          bus.ENTREGAR_DINERO = 1'b0;
          bus.CARGA_STB       = 1'b0;
        end
        bus.BILLETE_ACK = 1'b1;
        @(posedge clk); #1;
        bus.BILLETE_ACK = 1'b0;
        verificar({tag, " req baja"}, 32'(bus.BILLETE_REQ), 32'd0);
        verificar({tag, " completa temprana"}, 32'(bus.ENTREGA_COMPLETA), 32'd0);
      end
      @(posedge clk); #1;
      verificar({tag, " completa"}, 32'(bus.ENTREGA_COMPLETA), 32'd1);
      verificar({tag, " ocupado en fin"}, 32'(bus.OCUPADO), 32'd1);
      @(posedge clk); #1;
      verificar({tag, " completa pulso"}, 32'(bus.ENTREGA_COMPLETA), 32'd0);
      verificar({tag, " ocupado fin"}, 32'(bus.OCUPADO), 32'd0);
    end
  endtask

  initial begin
    int t;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.ENTREGAR_DINERO = 1'b0;
    bus.MONTO           = 32'd0;
    bus.CARGA_STB       = 1'b0;
    bus.CARGA_DENOM     = 2'd0;
    bus.CARGA_CANT      = 8'd0;
    bus.BILLETE_ACK     = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    verificar("reset req",      32'(bus.BILLETE_REQ),      32'd0);
    verificar("reset denom",    32'(bus.BILLETE_DENOM),    32'd0);
    verificar("reset ocupado",  32'(bus.OCUPADO),          32'd0);
    verificar("reset completa", 32'(bus.ENTREGA_COMPLETA), 32'd0);
    verificar("reset invalido", 32'(bus.MONTO_INVALIDO),   32'd0);
    verificar("reset falla",    32'(bus.FALLA_MECANISMO),  32'd0);

    // 5 of each; 36000 = 20000+10000+5000+1000; then 120000 shows 4,4 left in den 0,1.
    for (int d = 0; d < 4; d++) cargar(2'(d), 8'd5);
    entregar("t36000", 32'd36000, 1, 1, 1, 1, 8, 0);
    entregar("t120000", 32'd120000, 4, 4, 0, 0, -1, 0);

    // {0,5,5,5}: 40000 -> four 10000 bills; 20000 then shows only one 10000 left.
    reinicio();
    for (int d = 1; d < 4; d++) cargar(2'(d), 8'd5);
    entregar("t40000", 32'd40000, 0, 4, 0, 0, 9, 0);
    entregar("t20000", 32'd20000, 0, 1, 2, 0, -1, 0);

    // {1,1,1,1}: greedy leaves 4000 -> rejected; 1500 and 0 too; inventory intact afterwards.
    reinicio();
    for (int d = 0; d < 4; d++) cargar(2'(d), 8'd1);
    entregar("r40000", 32'd40000, 0, 0, 0, 0, -1, 0);
    entregar("r1500",  32'd1500,  0, 0, 0, 0, -1, 0);
    entregar("r0",     32'd0,     0, 0, 0, 0, -1, 0);
    entregar("t36000b", 32'd36000, 1, 1, 1, 1, -1, 0);

    // ACK stalled 10 cycles with a request and a load applied meanwhile; both must be ignored.
    reinicio();
    cargar(2'd3, 8'd2);
    entregar("espera", 32'd1000, 0, 0, 0, 1, 8, 10);
    @(posedge clk); #1;
    verificar("espera ocupado ignorado", 32'(bus.OCUPADO), 32'd0);
    entregar("r2000", 32'd2000, 0, 0, 0, 0, -1, 0);

    // 200 + 100 saturates at 255 bills of 1000.
    reinicio();
    cargar(2'd3, 8'd200);
    cargar(2'd3, 8'd100);
    entregar("sat", 32'd255000, 0, 0, 0, 255, -1, 0);

    // Reset during the second bill of three.
    reinicio();
    cargar(2'd2, 8'd3);
    pedir(32'd15000);
    t = 0;
    while (!bus.BILLETE_REQ && t < 100) begin @(posedge clk); #1; t++; end
    verificar("rst req1", 32'(bus.BILLETE_REQ), 32'd1);
    bus.BILLETE_ACK = 1'b1;
    @(posedge clk); #1;
    bus.BILLETE_ACK = 1'b0;
    t = 0;
    while (!bus.BILLETE_REQ && t < 100) begin @(posedge clk); #1; t++; end
    verificar("rst req2", 32'(bus.BILLETE_REQ), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    verificar("rst req async", 32'(bus.BILLETE_REQ), 32'd0);
    verificar("rst ocupado async", 32'(bus.OCUPADO), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      verificar("rst post req",      32'(bus.BILLETE_REQ),      32'd0);
      verificar("rst post ocupado",  32'(bus.OCUPADO),          32'd0);
      verificar("rst post completa", 32'(bus.ENTREGA_COMPLETA), 32'd0);
    end
    entregar("rst inventario", 32'd5000, 0, 0, 0, 0, -1, 0);

`ifdef DISPENSADOR_TIMEOUT_EN
    reinicio();
    cargar(2'd3, 8'd1);
    pedir(32'd1000);
    t = 0;
    while (!bus.BILLETE_REQ && t < 100) begin @(posedge clk); #1; t++; end
    verificar("to req", 32'(bus.BILLETE_REQ), 32'd1);
    t = 0;
    while (!bus.FALLA_MECANISMO && t < 100) begin @(posedge clk); #1; t++; end
    verificar("to ciclos", 32'(t), 32'd20);
    verificar("to req baja", 32'(bus.BILLETE_REQ), 32'd0);
    verificar("to ocupado", 32'(bus.OCUPADO), 32'd0);
    @(posedge clk); #1;
    verificar("to pulso", 32'(bus.FALLA_MECANISMO), 32'd0);
`else
    verificar("falla fija", 32'(bus.FALLA_MECANISMO), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
